// File: rtl/frame_mem_pkg.sv
// Shared constants and state encoding for the frame RAM write arbiter.
// Used by frame_mem_write_arbiter and frame_clear_seq.
package frame_mem_pkg;

  localparam int NPIX = 307200;
  localparam int AW   = 20;
  localparam int DW   = 9;

  localparam logic [DW-1:0] CLEAR_VAL_DEFAULT = 9'h000;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/frame_clear_seq.sv
// Clear address sequencer: walks 0..NPIX-1 one step per active cycle,
// restarts on i_start and pulses o_done the cycle after the final step.
module frame_clear_seq #(
  parameter int NPIX = 307200,
  parameter int AW   = 20
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_active,
  output logic          o_step,
  output logic          o_last,
  output logic [AW-1:0] o_addr,
  output logic          o_done
);

  logic [AW-1:0] r_cnt;
  logic          r_done;
  logic          w_step;
  logic          w_last;

  // A restart cycle issues no write; the walk resumes from 0 next cycle.
  assign w_step = i_active & ~i_start;
  assign w_last = w_step & (r_cnt == AW'(NPIX - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (i_start) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_step = w_step;
  assign o_last = w_last;
  assign o_addr = r_cnt;
  assign o_done = r_done;

endmodule

// File: rtl/frame_mem_write_arbiter.sv
// Owns the frame RAM write port: full-frame clear sequencing plus camera/cursor
// write muxing. Optional FRAME_MEM_ARB_CLEAR_COLOR_EN adds a programmable clear colour.
module frame_mem_write_arbiter
  import frame_mem_pkg::*;
#(
  parameter int NPIX = frame_mem_pkg::NPIX,
  parameter int AW   = frame_mem_pkg::AW,
  parameter int DW   = frame_mem_pkg::DW
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_mode,
  input  logic          i_clear_req,
`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
  input  logic [DW-1:0] i_clear_color,
`endif
  input  logic          i_cam_valid,
  output logic          o_cam_ready,
  input  logic [AW-1:0] i_cam_addr,
  input  logic [7:0]    i_cam_data,
  input  logic          i_cur_valid,
  output logic          o_cur_ready,
  input  logic [AW-1:0] i_cur_addr,
  input  logic [DW-1:0] i_cur_data,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic          o_clearing,
  output logic          o_cleared
);

  arb_state_e    r_state;
  arb_state_e    w_state_nx;
  logic          r_mode_q;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;

  logic          w_start;
  logic          w_fall;
  logic          w_step;
  logic          w_last;
  logic          w_done;
  logic [AW-1:0] w_seq_addr;
  logic [DW-1:0] w_clear_val;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  frame_clear_seq #(
    .NPIX (NPIX),
    .AW   (AW)
  ) u_clear_seq (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (w_start),
    .i_active  (r_state == ST_CLEAR),
    .o_step    (w_step),
    .o_last    (w_last),
    .o_addr    (w_seq_addr),
    .o_done    (w_done)
  );

`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
  logic [DW-1:0] r_clear_color;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_clear_color <= DW'(CLEAR_VAL_DEFAULT);
    end else if (w_start) begin
      r_clear_color <= i_clear_color;
    end
  end

  assign w_clear_val = r_clear_color;
`else
  assign w_clear_val = DW'(CLEAR_VAL_DEFAULT);
`endif

  // Only a paint-mode return from camera mode forces a clear.
  assign w_fall = r_mode_q & ~i_mode;

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (i_clear_req) begin
          w_start = 1'b1;
        end else if (w_last) begin
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_clear_req || w_fall) begin
          w_start    = 1'b1;
          w_state_nx = ST_CLEAR;
        end
      end
      default: w_state_nx = ST_CLEAR;
    endcase
  end

  // Out-of-range and non-selected transfers are accepted but never written.
  always_comb begin
    w_we   = 1'b0;
    w_addr = r_mem_addr;
    w_data = r_mem_data;
    if (w_step) begin
      w_we   = 1'b1;
      w_addr = w_seq_addr;
      w_data = w_clear_val;
    end else if (r_state == ST_RUN) begin
      if (i_mode) begin
        if (i_cam_valid && (i_cam_addr < AW'(NPIX))) begin
          w_we   = 1'b1;
          w_addr = i_cam_addr;
          w_data = DW'(i_cam_data);
        end
      end else begin
        if (i_cur_valid && (i_cur_addr < AW'(NPIX))) begin
          w_we   = 1'b1;
          w_addr = i_cur_addr;
          w_data = i_cur_data;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_CLEAR;
      r_mode_q   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_mode_q   <= i_mode;
      r_mem_we   <= w_we;
      r_mem_addr <= w_addr;
      r_mem_data <= w_data;
    end
  end

  assign o_cam_ready = (r_state == ST_RUN);
  assign o_cur_ready = (r_state == ST_RUN);
  assign o_clearing  = (r_state == ST_CLEAR);
  assign o_cleared   = w_done;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;

endmodule

// File: tb/tb_frame_mem_write_arbiter.sv
// Directed bench for frame_mem_write_arbiter with a 16-pixel frame.
// Covers FRAME_MEM_ARB_CLEAR_COLOR_EN when the macro is defined.
module tb_frame_mem_write_arbiter;

  localparam int NPIX = 16;
  localparam int AW   = 20;
  localparam int DW   = 9;

  logic          clk;
  logic          reset_n;
  logic          mode;
  logic          clear_req;
  logic          cam_valid;
  logic          cam_ready;
  logic [AW-1:0] cam_addr;
  logic [7:0]    cam_data;
  logic          cur_valid;
  logic          cur_ready;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          clearing;
  logic          cleared;
`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
  logic [DW-1:0] clear_color;
`endif

  int total = 0;
  int bad   = 0;

  frame_mem_write_arbiter #(
    .NPIX (NPIX),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_mode        (mode),
    .i_clear_req   (clear_req),
`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
    .i_clear_color (clear_color),
`endif
    .i_cam_valid   (cam_valid),
    .o_cam_ready   (cam_ready),
    .i_cam_addr    (cam_addr),
    .i_cam_data    (cam_data),
    .i_cur_valid   (cur_valid),
    .o_cur_ready   (cur_ready),
    .i_cur_addr    (cur_addr),
    .i_cur_data    (cur_data),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_data    (mem_data),
    .o_clearing    (clearing),
    .o_cleared     (cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic          cam_v;
    logic [AW-1:0] cam_a;
    logic [7:0]    cam_d;
    logic          cur_v;
    logic [AW-1:0] cur_a;
    logic [DW-1:0] cur_d;
    logic          exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    cam_valid = 1'b0;
    cur_valid = 1'b0;
    cam_addr  = '0;
    cam_data  = '0;
    cur_addr  = '0;
    cur_data  = '0;
  endtask

  // Counts writes until cleared pulses; optional restart after restart_at writes.
  task automatic run_clear(input string name, input int restart_at, input logic [DW-1:0] exp_d,
                           output int nwr);
    bit seen = 0;
    bit rs_done = 0;
    nwr = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      clear_req = 1'b0;
      if (mem_we) begin
        nwr++;
        if (mem_data !== exp_d) check({name, "_data"}, 32'(mem_data), 32'(exp_d));
      end
      if (cam_ready && !cleared) check({name, "_ready_low"}, 32'(cam_ready), 32'd0);
      if (cleared) seen = 1;
      if (!rs_done && restart_at >= 0 && nwr == restart_at) begin
        clear_req = 1'b1;
        rs_done = 1;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    mode    = 1'b0;
    idle_inputs();
`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
    clear_color = 9'h000;
`endif

    vecs[0] = '{1'b0, 1'b1, 20'd6,  8'h55, 1'b1, 20'd5,  9'h1C0, 1'b1, 20'd5,  9'h1C0};
    vecs[1] = '{1'b0, 1'b0, 20'd0,  8'h00, 1'b1, 20'd16, 9'h1FF, 1'b0, 20'd0,  9'h000};
    vecs[2] = '{1'b0, 1'b0, 20'd0,  8'h00, 1'b1, 20'd15, 9'h0F7, 1'b1, 20'd15, 9'h0F7};
    vecs[3] = '{1'b0, 1'b0, 20'd0,  8'h00, 1'b0, 20'd3,  9'h111, 1'b0, 20'd0,  9'h000};
    vecs[4] = '{1'b0, 1'b1, 20'd2,  8'h12, 1'b0, 20'd0,  9'h000, 1'b0, 20'd0,  9'h000};
    vecs[5] = '{1'b1, 1'b1, 20'd3,  8'hAB, 1'b1, 20'd4,  9'h001, 1'b1, 20'd3,  9'h0AB};
    vecs[6] = '{1'b1, 1'b1, 20'd16, 8'h77, 1'b0, 20'd0,  9'h000, 1'b0, 20'd0,  9'h000};
    vecs[7] = '{1'b1, 1'b1, 20'd0,  8'hFF, 1'b0, 20'd0,  9'h000, 1'b1, 20'd0,  9'h0FF};
    vecs[8] = '{1'b1, 1'b0, 20'd0,  8'h00, 1'b1, 20'd9,  9'h1AA, 1'b0, 20'd0,  9'h000};

    #23;
    check("rst_we",       32'(mem_we),    32'd0);
    check("rst_addr",     32'(mem_addr),  32'd0);
    check("rst_data",     32'(mem_data),  32'd0);
    check("rst_clearing", 32'(clearing),  32'd1);
    check("rst_cleared",  32'(cleared),   32'd0);
    check("rst_ready",    32'({cam_ready, cur_ready}), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      tick();
      check("init_we",      32'(mem_we),   32'd1);
      check("init_addr",    32'(mem_addr), 32'(i));
      check("init_data",    32'(mem_data), 32'd0);
      check("init_cleared", 32'(cleared),  32'(i == NPIX - 1));
      check("init_ready",   32'(cur_ready), 32'(i == NPIX - 1));
    end
    tick();
    check("post_cleared",  32'(cleared),  32'd0);
    check("post_clearing", 32'(clearing), 32'd0);

    for (int v = 0; v < 9; v++) begin
      mode      = vecs[v].mode;
      cam_valid = vecs[v].cam_v;
      cam_addr  = vecs[v].cam_a;
      cam_data  = vecs[v].cam_d;
      cur_valid = vecs[v].cur_v;
      cur_addr  = vecs[v].cur_a;
      cur_data  = vecs[v].cur_d;
      check($sformatf("vec%0d_cam_rdy", v), 32'(cam_ready), 32'd1);
      check($sformatf("vec%0d_cur_rdy", v), 32'(cur_ready), 32'd1);
      tick();
      check($sformatf("vec%0d_we", v), 32'(mem_we), 32'(vecs[v].exp_we));
      if (vecs[v].exp_we) begin
        check($sformatf("vec%0d_addr", v), 32'(mem_addr), 32'(vecs[v].exp_a));
        check($sformatf("vec%0d_data", v), 32'(mem_data), 32'(vecs[v].exp_d));
      end
      check($sformatf("vec%0d_clearing", v), 32'(clearing), 32'd0);
    end
    idle_inputs();

    // Mode fall with a cursor write on the trigger cycle: write lands, then clear.
    mode = 1'b0; cur_valid = 1'b1; cur_addr = 20'd7; cur_data = 9'h1AA;
    tick();
    idle_inputs();
    check("fall_we",       32'(mem_we),    32'd1);
    check("fall_addr",     32'(mem_addr),  32'd7);
    check("fall_data",     32'(mem_data),  32'h1AA);
    check("fall_clearing", 32'(clearing),  32'd1);
    check("fall_ready",    32'(cam_ready), 32'd0);
    for (int i = 0; i < NPIX; i++) begin
      tick();
      check("fall_clr_addr",  32'(mem_addr),  32'(i));
      check("fall_clr_we",    32'(mem_we),    32'd1);
      check("fall_clr_ready", 32'(cur_ready), 32'(i == NPIX - 1));
    end
    tick();

    // Rising edge must not clear.
    mode = 1'b1;
    tick();
    tick();
    check("rise_noclr", 32'(clearing), 32'd0);

    // clear_req coincident with the mode fall: exactly one clear.
    mode = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    run_clear("coinc", -1, 9'h000, n);
    check("coinc_writes", 32'(n), 32'(NPIX));
    for (int i = 0; i < 20; i++) tick();
    check("coinc_single", 32'({clearing, cleared}), 32'd0);

    // Restart after 7 clear writes: 7 + 16 writes before cleared.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    run_clear("restart", 7, 9'h000, n);
    check("restart_writes", 32'(n), 32'd23);
    tick();

    // Out-of-range cursor address is accepted but never written.
    cur_valid = 1'b1; cur_addr = 20'd16; cur_data = 9'h0AA;
    check("oor_ready", 32'(cur_ready), 32'd1);
    tick();
    idle_inputs();
    check("oor_we", 32'(mem_we), 32'd0);

    // Async reset mid-clear restarts from address 0.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("mrst_we",       32'(mem_we),   32'd0);
    check("mrst_clearing", 32'(clearing), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("mrst_addr0", 32'(mem_addr), 32'd0);
    check("mrst_we1",   32'(mem_we),   32'd1);
    run_clear("mrst", -1, 9'h000, n);
    check("mrst_writes", 32'(n), 32'(NPIX - 1));

`ifdef FRAME_MEM_ARB_CLEAR_COLOR_EN
    tick();
    clear_color = 9'h1FF;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    clear_color = 9'h055;
    run_clear("color", -1, 9'h1FF, n);
    check("color_writes", 32'(n), 32'(NPIX));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/frame_mem_write_arbiter.md
# frame_mem_write_arbiter

Owns the single write port of the 640x480 frame RAM and shares it between the camera pixel writer, the cursor painter and an internal clear sequencer. Sits between the camera/cursor producers and the dual-port RAM, replacing the ad-hoc write mux and RAM-initialisation handshake in the top level. Sequences a full-frame clear after reset, on request, and whenever the display returns from camera mode to paint mode.

## Interface
- `NPIX`, 307200: number of pixel addresses cleared and accepted (640*480).
- `AW`, 20: address width.
- `DW`, 9: RAM word width (RGB 3:3:3).
- `clk` in 1: system clock (50 MHz domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = paint (cursor owns RAM), 1 = camera.
- `clear_req` in 1: single-cycle pulse requesting a full clear.
- `cam_valid` in 1: camera write request.
- `cam_ready` out 1: camera write accepted this cycle.
- `cam_addr` in AW: camera pixel address.
- `cam_data` in 8: grey byte, zero-extended to DW.
- `cur_valid` in 1: cursor write request.
- `cur_ready` out 1: cursor write accepted this cycle.
- `cur_addr` in AW: cursor pixel address.
- `cur_data` in DW: paint colour.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out AW: RAM write address.
- `mem_data` out DW: RAM write data.
- `clearing` out 1: high while CLEAR state is active.
- `cleared` out 1: one-cycle pulse after the final clear write.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with counter 0.
- CLEAR: one write per cycle, `mem_addr`=counter, `mem_data`=clear value, counter 0..NPIX-1. After the write of NPIX-1: `cleared` pulses, go to RUN. `cam_ready`=`cur_ready`=0.
- RUN: `cam_ready`=`cur_ready`=1 (combinational from state). Transfer = valid && ready. Source selected by current `mode`: mode=1 writes camera transfers, mode=0 writes cursor transfers; the non-selected source's transfers are accepted and discarded.
- Transfers with addr >= NPIX: accepted, discarded, no `mem_we`.
- `mode_q` register tracks previous mode (reset 0). Falling edge (mode_q=1, mode=0) in RUN: go to CLEAR, counter 0. Rising edge: no clear.
- `clear_req` in RUN: go to CLEAR. `clear_req` during CLEAR: restart counter at 0.
- `clear_req` coincident with mode falling edge: one clear only.
- Mode changes during CLEAR are ignored for sequencing; RUN uses the live `mode` on entry.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `clearing`=1 (state CLEAR), `cleared`=0, `cam_ready`=`cur_ready`=0.
- `mem_we`/`mem_addr`/`mem_data` are registered: one cycle after the accepted transfer or the clear step.
- First clear write appears on the cycle after reset release; a full clear takes NPIX cycles; `cleared` is asserted on the cycle after the last clear write register update, coincident with the first RUN cycle.
- Trigger cycle (clear_req or mode fall) in RUN: that cycle's transfers are still accepted and written; CLEAR begins next cycle.
- Async reset mid-clear: counter returns to 0 and the clear restarts.

## Configuration
- `FRAME_MEM_ARB_CLEAR_COLOR_EN`: defined -> extra input `clear_color` [DW-1:0], sampled into a register on entry to CLEAR (including restart) and written as clear value. Undefined -> port absent, clear value 9'h000.

## Structure
- Package `frame_mem_pkg`: `NPIX`, `AW`, `DW`, state enum (`ST_CLEAR`, `ST_RUN`), default clear value.
- Sub-module `frame_clear_seq`: address counter with start/restart, done pulse, step strobe.

## Test plan
- NPIX=16, release reset -> `mem_we` high 16 consecutive cycles, addr 0..15, data 0; `cleared` pulse once; then `clearing`=0.
- RUN, mode=0, cur_valid with addr 5 data 9'h1C0, cam_valid with addr 6 -> single write addr 5 data 1C0 one cycle later; camera dropped.
- mode=1, cam_data 8'hAB addr 3 -> `mem_data`=9'h0AB at addr 3; then mode 1->0 -> 16-cycle clear, ready low throughout.
- clear_req at clear step 7 -> counter restarts at 0, total 23 clear writes before `cleared`.
- cur_addr=NPIX (16) in RUN -> `cur_ready`=1, `mem_we` stays 0.
- With macro, clear_color=9'h1FF, clear_req -> all 16 writes carry 1FF; changing clear_color mid-clear has no effect.
